// File: rtl/seq_generator.sv
// rtl/seq_generator.sv - MSB-first serial pattern transmitter (optional SEQ_GEN_PARITY_EN appends an even-parity bit)
module seq_generator #(
  parameter int PAT_W = 64,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  // The parity bit, when enabled, rides in the shift register below the pattern
  // so it is sent exactly like one more data bit.
  localparam int SR_W  = PAT_W + PAR_W;
  localparam int CNT_W = $clog2(PAT_W + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  len_eff;
  logic [PAT_W-1:0]  aligned;
  logic [SR_W-1:0]   load_sr;
  logic [CNT_W-1:0]  load_cnt;

  // Clamp the length and left-align the pattern so pat[len-1] lands in the MSB;
  // bits above len-1 fall off the top of the shift.
  always_comb begin
    len_eff  = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    aligned  = pat << (LEN_W'(PAT_W) - len_eff);
`ifdef SEQ_GEN_PARITY_EN
    load_sr  = {aligned, ^aligned};
`else
    load_sr  = aligned;
`endif
    load_cnt = CNT_W'(len_eff) + CNT_W'(PAR_W);
  end

  // State and output registers; reset discards any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load in IDLE, advance one bit per bit_en in SHIFT, pulse done in FIN.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          sr_d    = load_sr;
          cnt_d   = load_cnt;
          dout_d  = load_sr[SR_W-1];
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d  = cnt_q - CNT_W'(1);
            sr_d   = sr_q << 1;
            dout_d = sr_q[SR_W-2];
          end else begin
            cnt_d   = '0;
            dout_d  = 1'b0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        dout_d  = 1'b0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// tb/tb_seq_generator.sv - scoreboard bench for seq_generator
module tb_seq_generator;
  localparam int PAT_W = 64;
  localparam int LEN_W = 7;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pat = '0;
  logic [LEN_W-1:0] len = '0;
  logic             bit_en = 1'b0;
  logic             dout, dout_vld, busy, done;

  // Expected output stream: 0/1 = a bit period, 2 = the done cycle.
  int q[$];
  int errors = 0;
  int checks = 0;

  seq_generator #(.PAT_W(PAT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len), .bit_en(bit_en),
    .dout(dout), .dout_vld(dout_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle out of reset the outputs must match the head of the expected stream.
  always @(negedge clk) begin
    if (rst) begin
      if (q.size() == 0) begin
        check("idle", int'({dout_vld, busy, done, dout}), 0);
      end else if (q[0] == 2) begin
        check("fin", int'({dout, dout_vld, busy, done}), 4'b0001);
        void'(q.pop_front());
      end else begin
        int e;
        e = q[0];
        check("bit", int'({dout_vld, busy, done, dout}), int'({3'b110, e[0]}));
        if (bit_en) void'(q.pop_front());
      end
    end
  end

  // Issue one transfer. mode 0: bit_en always 1; 1: random; 2: every 3rd cycle.
  task automatic send(input logic [PAT_W-1:0] p, input int l, input int mode, input bit noisy);
    int eff, n, par, en_cycle;
    eff = (l > PAT_W) ? PAT_W : l;
    start  = 1'b1;
    pat    = p;
    len    = LEN_W'(l);
    bit_en = (mode == 0) ? 1'b1 : 1'($urandom % 2);
    @(posedge clk); #1;
    start  = 1'b0;
    bit_en = 1'b0;
    if (eff == 0) begin
      repeat (3) @(posedge clk);
      #1;
      return;
    end
    par = 0;
    for (int i = eff - 1; i >= 0; i--) begin
      q.push_back(int'(p[i]));
      par ^= int'(p[i]);
    end
    if (PAR == 1) q.push_back(par);
    q.push_back(2);
    n = eff + PAR;
    en_cycle = 0;
    while (n > 0) begin
      case (mode)
        0:       bit_en = 1'b1;
        1:       bit_en = ($urandom % 3) != 0;
        default: bit_en = (en_cycle % 3) == 2;
      endcase
      if (noisy) begin
        start = 1'($urandom % 2);
        pat   = {$urandom, $urandom};
        len   = LEN_W'($urandom_range(1, 127));
      end
      en_cycle++;
      if (bit_en) n--;
      @(posedge clk); #1;
    end
    // FIN cycle: a start here must be ignored.
    start  = noisy;
    bit_en = 1'($urandom % 2);
    pat    = {$urandom, $urandom};
    len    = LEN_W'($urandom_range(1, 127));
    @(posedge clk); #1;
    start  = 1'b0;
    bit_en = 1'b0;
  endtask

  // Reset in the middle of bit 5 of a 16-bit transfer.
  task automatic reset_mid();
    logic [PAT_W-1:0] p;
    int par;
    p = {$urandom, $urandom};
    start  = 1'b1;
    pat    = p;
    len    = LEN_W'(16);
    bit_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    par = 0;
    for (int i = 15; i >= 0; i--) begin
      q.push_back(int'(p[i]));
      par ^= int'(p[i]);
    end
    if (PAR == 1) q.push_back(par);
    q.push_back(2);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async", int'({dout, dout_vld, busy, done}), 0);
    q.delete();
    bit_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [PAT_W-1:0] p43;
    p43 = 64'b1101101101000101101110111101000101010110101;
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("reset_state", int'({dout, dout_vld, busy, done}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    send(64'b1101, 4, 0, 1'b0);
    send(p43, 43, 0, 1'b0);
    send(64'b1011, 4, 2, 1'b0);
    send({$urandom, $urandom}, 8, 1, 1'b1);
    reset_mid();
    send({$urandom, $urandom}, 16, 0, 1'b0);
    send({$urandom, $urandom}, 0, 0, 1'b0);
    send({$urandom, $urandom}, 100, 0, 1'b0);
    for (int t = 0; t < 30; t++) begin
      int l;
      l = (($urandom % 8) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(1, 64));
      send({$urandom, $urandom}, l, int'($urandom % 3), 1'($urandom % 2));
      if (($urandom % 4) == 0) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
